video_format_detector: RTL and testbench



---
 rtl/video_format_detector.sv | 176 +++++++++++++++++
 tb/tb_video_format_detector.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/video_format_detector.sv
// Classifies incoming analogue sync timing into the monitor interface's video format code.
// A format is only reported once several consecutive fields agree; loss of sync forces code 0.
module video_format_detector #(
  parameter int unsigned STABLE_FIELDS = 4,
  parameter int unsigned H_TIMEOUT     = 8000,
  parameter int unsigned V_TIMEOUT     = 2500000,
  parameter int unsigned H_MIN_GAP     = 1000,
  parameter int unsigned H_I_MIN       = 2900,
  parameter int unsigned H_I_MAX       = 3500,
  parameter int unsigned H_P_MIN       = 1450,
  parameter int unsigned H_P_MAX       = 1750,
  parameter int unsigned L_576I_MIN    = 300,
  parameter int unsigned L_576I_MAX    = 330,
  parameter int unsigned L_480I_MIN    = 250,
  parameter int unsigned L_480I_MAX    = 275,
  parameter int unsigned L_576P_MIN    = 600,
  parameter int unsigned L_576P_MAX    = 650,
  parameter int unsigned L_480P_MIN    = 510,
  parameter int unsigned L_480P_MAX    = 540
) (
  input  logic        clk_50mhz_in,
  input  logic        reset_x,
  input  logic        hsync_x,
  input  logic        vsync_x,
  output logic [7:0]  video_format,
  output logic        locked,
  output logic        format_changed,
  output logic [11:0] h_period,
  output logic [9:0]  line_count
);

  localparam int unsigned HW = 13;
  localparam int unsigned VW = 22;
  localparam int unsigned PW = 12;
  localparam int unsigned LW = 10;
  localparam int unsigned SW = $clog2(STABLE_FIELDS + 1);

  logic [2:0]    hs_sr, vs_sr;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_wd;
  logic [LW-1:0] line_cnt;
  logic          armed, armed_n;
  logic [7:0]    candidate, candidate_n;
  logic [SW-1:0] stable_cnt, stable_cnt_n;
  logic          upd_pend, upd_pend_n;
  logic [7:0]    video_format_n;
  logic          locked_n, format_changed_n;

  logic          hs_fall_c, vs_fall_c, hs_acc_c, loss_c;
  logic [PW-1:0] h_clip_c, h_now_c;
  logic [LW-1:0] line_inc_c, lines_closed_c;
  logic [7:0]    cls_c;

  // Two synchroniser stages followed by an edge register; syncs idle high
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      hs_sr <= 3'b111;
      vs_sr <= 3'b111;
    end else begin
      hs_sr <= {hs_sr[1:0], hsync_x};
      vs_sr <= {vs_sr[1:0], vsync_x};
    end
  end

  // Edge qualification, loss detection and field classification
  always_comb begin
    hs_fall_c      = hs_sr[2] & ~hs_sr[1];
    vs_fall_c      = vs_sr[2] & ~vs_sr[1];
    hs_acc_c       = hs_fall_c && (h_cnt >= HW'(H_MIN_GAP));
    h_clip_c       = h_cnt[HW-1] ? '1 : h_cnt[PW-1:0];
    line_inc_c     = (line_cnt == '1) ? line_cnt : line_cnt + LW'(1);
    lines_closed_c = hs_acc_c ? line_inc_c : line_cnt;
    h_now_c        = hs_acc_c ? h_clip_c : h_period;
    // The edge that clears a counter also ends its own loss condition
    loss_c         = ((h_cnt >= HW'(H_TIMEOUT)) && !hs_acc_c) ||
                     ((v_wd >= VW'(V_TIMEOUT)) && !vs_fall_c);
    cls_c          = 8'd0;
    if (h_now_c >= PW'(H_I_MIN) && h_now_c <= PW'(H_I_MAX)) begin
      if (lines_closed_c >= LW'(L_576I_MIN) && lines_closed_c <= LW'(L_576I_MAX))
        cls_c = 8'd1;
      else if (lines_closed_c >= LW'(L_480I_MIN) && lines_closed_c <= LW'(L_480I_MAX))
        cls_c = 8'd2;
    end else if (h_now_c >= PW'(H_P_MIN) && h_now_c <= PW'(H_P_MAX)) begin
      if (lines_closed_c >= LW'(L_576P_MIN) && lines_closed_c <= LW'(L_576P_MAX))
        cls_c = 8'd3;
      else if (lines_closed_c >= LW'(L_480P_MIN) && lines_closed_c <= LW'(L_480P_MAX))
        cls_c = 8'd4;
    end
  end

  // Line period, line count and vsync watchdog counters
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      h_cnt      <= '0;
      v_wd       <= '0;
      line_cnt   <= '0;
      h_period   <= '0;
      line_count <= '0;
    end else begin
      if (hs_acc_c) begin
        h_cnt    <= HW'(1);
        h_period <= h_clip_c;
      end else if (h_cnt != '1) begin
        h_cnt <= h_cnt + HW'(1);
      end
      if (vs_fall_c) begin
        line_cnt   <= '0;
        line_count <= lines_closed_c;
        v_wd       <= '0;
      end else begin
        if (hs_acc_c)
          line_cnt <= line_inc_c;
        if (v_wd != '1)
          v_wd <= v_wd + VW'(1);
      end
    end
  end

  // Stability tracking and output update, applied the clock after a classified field
  always_comb begin
    armed_n          = armed;
    candidate_n      = candidate;
    stable_cnt_n     = stable_cnt;
    upd_pend_n       = 1'b0;
    video_format_n   = video_format;
    format_changed_n = 1'b0;
    if (loss_c) begin
      armed_n          = 1'b0;
      candidate_n      = 8'd0;
      stable_cnt_n     = '0;
      video_format_n   = 8'd0;
      format_changed_n = (video_format != 8'd0);
    end else begin
      if (upd_pend && stable_cnt == SW'(STABLE_FIELDS) && candidate != video_format) begin
        video_format_n   = candidate;
        format_changed_n = 1'b1;
      end
      if (vs_fall_c) begin
        if (!armed) begin
          armed_n = 1'b1;
        end else begin
          upd_pend_n = 1'b1;
          if (cls_c == candidate) begin
            if (stable_cnt != SW'(STABLE_FIELDS))
              stable_cnt_n = stable_cnt + SW'(1);
          end else begin
            candidate_n  = cls_c;
            stable_cnt_n = SW'(1);
          end
        end
      end
    end
    locked_n = (stable_cnt_n == SW'(STABLE_FIELDS)) && (video_format_n != 8'd0);
  end

  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      armed          <= 1'b0;
      candidate      <= 8'd0;
      stable_cnt     <= '0;
      upd_pend       <= 1'b0;
      video_format   <= 8'd0;
      locked         <= 1'b0;
      format_changed <= 1'b0;
    end else begin
      armed          <= armed_n;
      candidate      <= candidate_n;
      stable_cnt     <= stable_cnt_n;
      upd_pend       <= upd_pend_n;
      video_format   <= video_format_n;
      locked         <= locked_n;
      format_changed <= format_changed_n;
    end
  end

endmodule

// File: tb/tb_video_format_detector.sv
// Directed bench for video_format_detector with sync timing scaled down (periods /100, lines /10)
// so whole fields fit in a short run; thresholds are overridden to match the scaling.
module tb_video_format_detector;

  logic        clk_50mhz_in = 1'b0;
  logic        reset_x;
  logic        hsync_x;
  logic        vsync_x;
  logic [7:0]  video_format;
  logic        locked;
  logic        format_changed;
  logic [11:0] h_period;
  logic [9:0]  line_count;

  video_format_detector #(
    .STABLE_FIELDS(4), .H_TIMEOUT(80), .V_TIMEOUT(2500), .H_MIN_GAP(10),
    .H_I_MIN(29), .H_I_MAX(35), .H_P_MIN(14), .H_P_MAX(17),
    .L_576I_MIN(30), .L_576I_MAX(33), .L_480I_MIN(25), .L_480I_MAX(27),
    .L_576P_MIN(60), .L_576P_MAX(65), .L_480P_MIN(51), .L_480P_MAX(54)
  ) dut (
    .clk_50mhz_in  (clk_50mhz_in),
    .reset_x       (reset_x),
    .hsync_x       (hsync_x),
    .vsync_x       (vsync_x),
    .video_format  (video_format),
    .locked        (locked),
    .format_changed(format_changed),
    .h_period      (h_period),
    .line_count    (line_count)
  );

  always #10 clk_50mhz_in = ~clk_50mhz_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int drops = 0;
  int drop_cyc = 0;
  logic [7:0] prev_vf = 8'd0;
  int last_h_cyc = 0;
  int last_v_cyc = 0;
  int last_lines = 0;
  int closed_lines = 0;
  int p0, d0, age;

  always @(posedge clk_50mhz_in) cyc <= cyc + 1;

  // Counts format_changed pulses and timestamps every non-reset drop to code 0
  always @(negedge clk_50mhz_in) begin
    if (format_changed) pulses <= pulses + 1;
    if (reset_x && prev_vf != 8'd0 && video_format == 8'd0) begin
      drop_cyc <= cyc;
      drops    <= drops + 1;
    end
    prev_vf <= video_format;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sync_line(input int period, input bit with_vs, input bit glitch);
    for (int c = 0; c < period; c++) begin
      @(posedge clk_50mhz_in); #1;
      hsync_x = !(c < 3 || (glitch && (c == 4 || c == 5)));
      vsync_x = !(with_vs && c < 3);
      if (c == 0) begin
        last_h_cyc = cyc;
        if (with_vs) last_v_cyc = cyc;
      end
    end
  endtask

  // One field: vsync falls together with its first hsync, which closes the previous field
  task automatic field(input int lines, input int period, input int glitch_line);
    closed_lines = last_lines;
    last_lines   = lines;
    for (int i = 0; i < lines; i++)
      sync_line(period, i == 0, i == glitch_line);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50mhz_in); #1;
      hsync_x = 1'b1;
      vsync_x = 1'b1;
    end
  endtask

  initial begin
    reset_x = 1'b0;
    hsync_x = 1'b1;
    vsync_x = 1'b1;
    repeat (3) @(posedge clk_50mhz_in);
    #1;
    check("rst_vf", int'(video_format), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_fc", int'(format_changed), 0);
    check("rst_hper", int'(h_period), 0);
    check("rst_lines", int'(line_count), 0);
    reset_x = 1'b1;

    // Idle syncs: watchdogs expire but code stays 0 with no pulse
    idle(3000);
    check("idle_vf", int'(video_format), 0);
    check("idle_locked", int'(locked), 0);
    check("idle_pulses", pulses, 0);

    // 576i, alternating 31/32 lines
    p0 = pulses;
    for (int i = 0; i < 4; i++) field(31 + (i % 2), 32, -1);
    check("576i_early_vf", int'(video_format), 0);
    field(31, 32, -1);
    check("576i_vf", int'(video_format), 1);
    check("576i_locked", int'(locked), 1);
    check("576i_hper", int'(h_period), 32);
    check("576i_lines", int'(line_count), closed_lines);
    field(32, 32, -1);
    field(31, 32, -1);
    check("576i_pulses", pulses - p0, 1);
    check("576i_hold_vf", int'(video_format), 1);

    // Switch to 480p: old code held for three fields, new code on the fourth
    p0 = pulses;
    for (int k = 1; k <= 5; k++) begin
      field(52, 16, -1);
      if (k >= 2 && k <= 4) check("480p_hold_vf", int'(video_format), 1);
    end
    check("480p_vf", int'(video_format), 4);
    check("480p_pulses", pulses - p0, 1);

    // Lock on 576p, then stop both syncs: horizontal timeout drops the code
    for (int k = 0; k < 5; k++) field(62, 16, -1);
    check("576p_vf", int'(video_format), 3);
    check("576p_locked", int'(locked), 1);
    p0 = pulses;
    d0 = drops;
    idle(200);
    age = drop_cyc - last_h_cyc;
    check("hloss_drops", drops - d0, 1);
    check("hloss_age_window", int'(age >= 76 && age <= 84), 1);
    check("hloss_vf", int'(video_format), 0);
    check("hloss_locked", int'(locked), 0);
    check("hloss_pulses", pulses - p0, 1);

    for (int k = 0; k < 4; k++) field(62, 16, -1);
    check("hrestart_early_vf", int'(video_format), 0);
    field(62, 16, -1);
    check("hrestart_vf", int'(video_format), 3);
    check("hrestart_locked", int'(locked), 1);

    // Vsync stops while hsync keeps running
    d0 = drops;
    for (int k = 0; k < 170; k++) sync_line(16, 1'b0, 1'b0);
    age = drop_cyc - last_v_cyc;
    check("vloss_drops", drops - d0, 1);
    check("vloss_age_window", int'(age >= 2496 && age <= 2504), 1);
    check("vloss_vf", int'(video_format), 0);
    check("vloss_locked", int'(locked), 0);
    for (int k = 0; k < 5; k++) field(62, 16, -1);
    check("vrestart_vf", int'(video_format), 3);

    // 480i lock, then a field containing an hsync glitch shortly after a real edge
    for (int k = 0; k < 5; k++) field(26 + (k % 2), 32, -1);
    check("480i_vf", int'(video_format), 2);
    check("480i_locked", int'(locked), 1);
    p0 = pulses;
    field(26, 32, 5);
    field(27, 32, -1);
    check("glitch_hper", int'(h_period), 32);
    check("glitch_lines", int'(line_count), 26);
    check("glitch_vf", int'(video_format), 2);
    check("glitch_pulses", pulses - p0, 0);

    // Reset mid-field clears outputs without waiting for a clock
    for (int k = 0; k < 10; k++) sync_line(32, 1'b0, 1'b0);
    reset_x = 1'b0;
    #2;
    check("midrst_vf", int'(video_format), 0);
    check("midrst_locked", int'(locked), 0);
    check("midrst_hper", int'(h_period), 0);
    check("midrst_lines", int'(line_count), 0);
    @(posedge clk_50mhz_in); #1;
    reset_x = 1'b1;
    idle(20);

    // 720p-like timing is unsupported; a stray field restarts the 576p count
    p0 = pulses;
    for (int k = 0; k < 5; k++) field(75, 16, -1);
    check("720p_vf", int'(video_format), 0);
    check("720p_locked", int'(locked), 0);
    field(62, 16, -1);
    field(62, 16, -1);
    field(75, 16, -1);
    check("stray_vf", int'(video_format), 0);
    for (int k = 0; k < 4; k++) field(62, 16, -1);
    check("stray_3of4_vf", int'(video_format), 0);
    field(62, 16, -1);
    check("stray_4of4_vf", int'(video_format), 3);
    check("stray_pulses", pulses - p0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
